// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: multiplexed hex 7-segment driver with blanking phase and tear-free double-buffered loads
module seven_seg_scanner #(
   parameter int N_DIGITS       = 4,
   parameter int BLANK_TICKS    = 1,
   parameter bit ACTIVE_LOW_SEG = 1'b1,
   parameter bit ACTIVE_LOW_AN  = 1'b1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  en_i,
   input  logic                  tick_i,
   input  logic [4*N_DIGITS-1:0] value_i,
   input  logic [N_DIGITS-1:0]   dp_i,
   input  logic                  load_i,
   input  logic                  lz_blank_i,
   output logic [6:0]            seg_o,
   output logic                  dp_out_o,
   output logic [N_DIGITS-1:0]   an_o,
   output logic                  frame_done_o,
   output logic                  load_ack_o
);
   localparam int IW = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;
   localparam int CW = BLANK_TICKS > 0 ? $clog2(BLANK_TICKS + 1) : 1;
   localparam logic [IW-1:0] LAST = IW'(N_DIGITS - 1);
   localparam logic [6:0] SEG_OFF = ACTIVE_LOW_SEG ? 7'h7F : 7'h00;
   localparam logic [N_DIGITS-1:0] AN_OFF = ACTIVE_LOW_AN ? '1 : '0;
   typedef enum logic [1:0] {OFF, BLANK, SHOW} state_t;
   state_t                state_q, state_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [4*N_DIGITS-1:0] disp_val_q, disp_val_d, pend_val_q, pend_val_d;
   logic [N_DIGITS-1:0]   disp_dp_q, disp_dp_d, pend_dp_q, pend_dp_d;
   logic                  pend_valid_q, pend_valid_d;
   logic [6:0]            seg_q, seg_d;
   logic                  dp_out_q, dp_out_d;
   logic [N_DIGITS-1:0]   an_q, an_d;
   logic                  frame_done_q, frame_done_d;
   logic                  load_ack_q, load_ack_d;
   logic                  xfer, run, blanked;
   logic [N_DIGITS-1:0]   hz;
   logic [3:0]            digit;
   function automatic logic [6:0] hex7(input logic [3:0] h);
      case (h)
         4'h0: hex7 = 7'h3F;
         4'h1: hex7 = 7'h06;
         4'h2: hex7 = 7'h5B;
         4'h3: hex7 = 7'h4F;
         4'h4: hex7 = 7'h66;
         4'h5: hex7 = 7'h6D;
         4'h6: hex7 = 7'h7D;
         4'h7: hex7 = 7'h07;
         4'h8: hex7 = 7'h7F;
         4'h9: hex7 = 7'h6F;
         4'hA: hex7 = 7'h77;
         4'hB: hex7 = 7'h7C;
         4'hC: hex7 = 7'h39;
         4'hD: hex7 = 7'h5E;
         4'hE: hex7 = 7'h79;
         default: hex7 = 7'h71;
      endcase
   endfunction
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      cnt_d        = cnt_q;
      disp_val_d   = disp_val_q;
      disp_dp_d    = disp_dp_q;
      pend_val_d   = load_i ? value_i : pend_val_q;
      pend_dp_d    = load_i ? dp_i : pend_dp_q;
      pend_valid_d = pend_valid_q | load_i;
      frame_done_d = 1'b0;
      xfer         = 1'b0;
      if (!en_i) begin
         state_d = OFF;
         idx_d   = '0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            OFF: begin
               state_d = BLANK_TICKS == 0 ? SHOW : BLANK;
               idx_d   = '0;
               cnt_d   = '0;
               xfer    = pend_valid_q;
            end
            BLANK: if (tick_i) begin
               state_d = int'(cnt_q) + 1 >= BLANK_TICKS ? SHOW : BLANK;
               cnt_d   = int'(cnt_q) + 1 >= BLANK_TICKS ? '0 : cnt_q + 1'b1;
            end
            SHOW: if (tick_i) begin
               state_d      = BLANK_TICKS == 0 ? SHOW : BLANK;
               frame_done_d = idx_q == LAST;
               idx_d        = idx_q == LAST ? '0 : idx_q + 1'b1;
               xfer         = idx_q == LAST && pend_valid_q;
            end
            default: state_d = OFF;
         endcase
      end
      // transfer takes the pre-load pending copy; a same-cycle load stays pending
      if (xfer) begin
         disp_val_d   = pend_val_q;
         disp_dp_d    = pend_dp_q;
         pend_valid_d = load_i;
      end
      run = 1'b1;
      hz  = '0;
      for (int i = N_DIGITS - 1; i >= 0; i--) begin
         run   = run & (disp_val_d[4*i +: 4] == 4'h0);
         hz[i] = run;
      end
      digit      = disp_val_d[4*idx_d +: 4];
      blanked    = lz_blank_i && idx_d != '0 && hz[idx_d];
      seg_d      = state_d != SHOW || blanked ? SEG_OFF : (ACTIVE_LOW_SEG ? ~hex7(digit) : hex7(digit));
      dp_out_d   = state_d == SHOW ? disp_dp_d[idx_d] ^ ACTIVE_LOW_SEG : ACTIVE_LOW_SEG;
      an_d       = state_d == SHOW ? (N_DIGITS'(1) << idx_d) ^ AN_OFF : AN_OFF;
      load_ack_d = xfer;
   end
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q      <= OFF;
         idx_q        <= '0;
         cnt_q        <= '0;
         disp_val_q   <= '0;
         disp_dp_q    <= '0;
         pend_val_q   <= '0;
         pend_dp_q    <= '0;
         pend_valid_q <= 1'b0;
         seg_q        <= SEG_OFF;
         dp_out_q     <= ACTIVE_LOW_SEG;
         an_q         <= AN_OFF;
         frame_done_q <= 1'b0;
         load_ack_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         cnt_q        <= cnt_d;
         disp_val_q   <= disp_val_d;
         disp_dp_q    <= disp_dp_d;
         pend_val_q   <= pend_val_d;
         pend_dp_q    <= pend_dp_d;
         pend_valid_q <= pend_valid_d;
         seg_q        <= seg_d;
         dp_out_q     <= dp_out_d;
         an_q         <= an_d;
         frame_done_q <= frame_done_d;
         load_ack_q   <= load_ack_d;
      end
   end
   assign seg_o        = seg_q;
   assign dp_out_o     = dp_out_q;
   assign an_o         = an_q;
   assign frame_done_o = frame_done_q;
   assign load_ack_o   = load_ack_q;
endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: vector table for the 4-digit default scanner plus hand sequences for reset and a 2-digit no-blank variant
module tb_seven_seg_scanner;
   logic        clk = 1'b0;
   logic        rst_n, en, tick, load, lz;
   logic [15:0] val;
   logic [3:0]  dp;
   logic [6:0]  seg;
   logic        dpo;
   logic [3:0]  an;
   logic        fd, ack;
   logic        en2, tick2, load2;
   logic [7:0]  val2;
   logic [1:0]  dp2;
   logic [6:0]  seg2;
   logic        dpo2;
   logic [1:0]  an2;
   logic        fd2, ack2;
   int          tests = 0;
   int          failed = 0;

   always #5 clk = ~clk;

   seven_seg_scanner dut (
      .clk_i(clk), .rst_ni(rst_n), .en_i(en), .tick_i(tick), .value_i(val), .dp_i(dp),
      .load_i(load), .lz_blank_i(lz), .seg_o(seg), .dp_out_o(dpo), .an_o(an),
      .frame_done_o(fd), .load_ack_o(ack)
   );

   seven_seg_scanner #(.N_DIGITS(2), .BLANK_TICKS(0)) dut2 (
      .clk_i(clk), .rst_ni(rst_n), .en_i(en2), .tick_i(tick2), .value_i(val2), .dp_i(dp2),
      .load_i(load2), .lz_blank_i(1'b0), .seg_o(seg2), .dp_out_o(dpo2), .an_o(an2),
      .frame_done_o(fd2), .load_ack_o(ack2)
   );

   typedef struct {
      logic en, tick, load, lz;
      logic [15:0] val;
      logic [3:0] dp;
      logic [6:0] seg;
      logic dpo;
      logic [3:0] an;
      logic fd, ack;
   } vec_t;
   vec_t tv[$];

   function automatic vec_t mk(logic e, logic t, logic l, logic z, logic [15:0] v, logic [3:0] d,
                               logic [6:0] s, logic p, logic [3:0] a, logic f, logic k);
      vec_t r;
      r.en = e; r.tick = t; r.load = l; r.lz = z; r.val = v; r.dp = d;
      r.seg = s; r.dpo = p; r.an = a; r.fd = f; r.ack = k;
      return r;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step2(string nm, logic e, logic t, logic l, logic [7:0] v,
                        logic [6:0] s, logic [1:0] a, logic f, logic k);
      en2 = e; tick2 = t; load2 = l; val2 = v;
      @(negedge clk);
      chk({nm, " seg"}, 32'(seg2), 32'(s));
      chk({nm, " an"}, 32'(an2), 32'(a));
      chk({nm, " fd"}, 32'(fd2), 32'(f));
      chk({nm, " ack"}, 32'(ack2), 32'(k));
      chk({nm, " dp"}, 32'(dpo2), 32'h1);
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; tick = 1'b0; load = 1'b0; lz = 1'b0; val = '0; dp = '0;
      en2 = 1'b0; tick2 = 1'b0; load2 = 1'b0; val2 = '0; dp2 = '0;
      // en tick load lz value dp | seg dp_out an frame_done load_ack
      tv.push_back(mk(0,0,1,0,16'h1234,4'h0, 7'h7F,1,4'hF,0,0));
      tv.push_back(mk(1,0,0,0,16'h0,4'h0, 7'h7F,1,4'hF,0,1));
      tv.push_back(mk(1,1,0,0,16'h0,4'h0, 7'h19,1,4'hE,0,0));
      tv.push_back(mk(1,0,0,0,16'h0,4'h0, 7'h19,1,4'hE,0,0));
      tv.push_back(mk(1,1,0,0,16'h0,4'h0, 7'h7F,1,4'hF,0,0));
      tv.push_back(mk(1,1,0,0,16'h0,4'h0, 7'h30,1,4'hD,0,0));
      tv.push_back(mk(1,1,1,0,16'hABCD,4'h0, 7'h7F,1,4'hF,0,0));
      tv.push_back(mk(1,1,0,0,16'h0,4'h0, 7'h24,1,4'hB,0,0));
      tv.push_back(mk(1,1,0,0,16'h0,4'h0, 7'h7F,1,4'hF,0,0));
      tv.push_back(mk(1,1,0,0,16'h0,4'h0, 7'h79,1,4'h7,0,0));
      tv.push_back(mk(1,1,0,0,16'h0,4'h0, 7'h7F,1,4'hF,1,1));
      tv.push_back(mk(1,1,0,0,16'h0,4'h0, 7'h21,1,4'hE,0,0));
      tv.push_back(mk(1,1,0,0,16'h0,4'h0, 7'h7F,1,4'hF,0,0));
      tv.push_back(mk(1,1,0,0,16'h0,4'h0, 7'h46,1,4'hD,0,0));
      tv.push_back(mk(1,1,0,0,16'h0,4'h0, 7'h7F,1,4'hF,0,0));
      tv.push_back(mk(1,1,0,0,16'h0,4'h0, 7'h03,1,4'hB,0,0));
      tv.push_back(mk(1,1,0,0,16'h0,4'h0, 7'h7F,1,4'hF,0,0));
      tv.push_back(mk(1,1,0,0,16'h0,4'h0, 7'h08,1,4'h7,0,0));
      tv.push_back(mk(1,1,0,0,16'h0,4'h0, 7'h7F,1,4'hF,1,0));
      tv.push_back(mk(0,0,1,1,16'h0042,4'h5, 7'h7F,1,4'hF,0,0));
      tv.push_back(mk(1,0,0,1,16'h0,4'h0, 7'h7F,1,4'hF,0,1));
      tv.push_back(mk(1,1,0,1,16'h0,4'h0, 7'h24,0,4'hE,0,0));
      tv.push_back(mk(1,1,0,1,16'h0,4'h0, 7'h7F,1,4'hF,0,0));
      tv.push_back(mk(1,1,0,1,16'h0,4'h0, 7'h19,1,4'hD,0,0));
      tv.push_back(mk(1,1,0,1,16'h0,4'h0, 7'h7F,1,4'hF,0,0));
      tv.push_back(mk(1,1,0,1,16'h0,4'h0, 7'h7F,0,4'hB,0,0));
      tv.push_back(mk(1,1,0,1,16'h0,4'h0, 7'h7F,1,4'hF,0,0));
      tv.push_back(mk(1,1,0,1,16'h0,4'h0, 7'h7F,1,4'h7,0,0));
      tv.push_back(mk(1,1,0,1,16'h0,4'h0, 7'h7F,1,4'hF,1,0));
      tv.push_back(mk(0,0,1,1,16'h0000,4'h0, 7'h7F,1,4'hF,0,0));
      tv.push_back(mk(1,0,0,1,16'h0,4'h0, 7'h7F,1,4'hF,0,1));
      tv.push_back(mk(1,1,0,1,16'h0,4'h0, 7'h40,1,4'hE,0,0));
      tv.push_back(mk(1,1,0,1,16'h0,4'h0, 7'h7F,1,4'hF,0,0));
      tv.push_back(mk(1,1,0,1,16'h0,4'h0, 7'h7F,1,4'hD,0,0));
      tv.push_back(mk(1,1,0,1,16'h0,4'h0, 7'h7F,1,4'hF,0,0));
      tv.push_back(mk(1,1,0,1,16'h0,4'h0, 7'h7F,1,4'hB,0,0));
      tv.push_back(mk(1,1,0,1,16'h0,4'h0, 7'h7F,1,4'hF,0,0));
      tv.push_back(mk(1,1,0,1,16'h0,4'h0, 7'h7F,1,4'h7,0,0));
      tv.push_back(mk(1,1,0,0,16'h0,4'h0, 7'h7F,1,4'hF,1,0));
      tv.push_back(mk(1,1,0,0,16'h0,4'h0, 7'h40,1,4'hE,0,0));
      tv.push_back(mk(1,1,0,0,16'h0,4'h0, 7'h7F,1,4'hF,0,0));
      tv.push_back(mk(1,1,0,0,16'h0,4'h0, 7'h40,1,4'hD,0,0));
      tv.push_back(mk(1,1,0,0,16'h0,4'h0, 7'h7F,1,4'hF,0,0));
      tv.push_back(mk(1,1,0,0,16'h0,4'h0, 7'h40,1,4'hB,0,0));
      tv.push_back(mk(0,0,0,0,16'h0,4'h0, 7'h7F,1,4'hF,0,0));
      tv.push_back(mk(0,1,0,0,16'h0,4'h0, 7'h7F,1,4'hF,0,0));
      tv.push_back(mk(0,1,0,0,16'h0,4'h0, 7'h7F,1,4'hF,0,0));
      tv.push_back(mk(1,0,0,0,16'h0,4'h0, 7'h7F,1,4'hF,0,0));
      tv.push_back(mk(1,1,0,0,16'h0,4'h0, 7'h40,1,4'hE,0,0));

      repeat (2) @(negedge clk);
      chk("reset seg", 32'(seg), 32'h7F);
      chk("reset dp", 32'(dpo), 32'h1);
      chk("reset an", 32'(an), 32'hF);
      chk("reset fd", 32'(fd), 32'h0);
      chk("reset ack", 32'(ack), 32'h0);
      chk("reset an2", 32'(an2), 32'h3);
      rst_n = 1'b1;

      foreach (tv[i]) begin
         en = tv[i].en; tick = tv[i].tick; load = tv[i].load; lz = tv[i].lz;
         val = tv[i].val; dp = tv[i].dp;
         @(negedge clk);
         chk($sformatf("row%0d seg", i), 32'(seg), 32'(tv[i].seg));
         chk($sformatf("row%0d dp", i), 32'(dpo), 32'(tv[i].dpo));
         chk($sformatf("row%0d an", i), 32'(an), 32'(tv[i].an));
         chk($sformatf("row%0d fd", i), 32'(fd), 32'(tv[i].fd));
         chk($sformatf("row%0d ack", i), 32'(ack), 32'(tv[i].ack));
      end

      // reset while showing digit 0, then confirm the display buffer was cleared
      en = 1'b1; tick = 1'b0; load = 1'b0; lz = 1'b0; rst_n = 1'b0;
      @(negedge clk);
      chk("midshow rst seg", 32'(seg), 32'h7F);
      chk("midshow rst dp", 32'(dpo), 32'h1);
      chk("midshow rst an", 32'(an), 32'hF);
      chk("midshow rst fd", 32'(fd), 32'h0);
      chk("midshow rst ack", 32'(ack), 32'h0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post rst enable ack", 32'(ack), 32'h0);
      chk("post rst enable an", 32'(an), 32'hF);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      chk("post rst digit0 seg", 32'(seg), 32'h40);
      chk("post rst digit0 an", 32'(an), 32'hE);
      en = 1'b0;

      step2("n2 idle", 0, 0, 1, 8'h21, 7'h7F, 2'b11, 0, 0);
      step2("n2 enable", 1, 0, 0, 8'h00, 7'h79, 2'b10, 0, 1);
      step2("n2 digit1", 1, 1, 0, 8'h00, 7'h24, 2'b01, 0, 0);
      step2("n2 preload", 1, 0, 1, 8'h43, 7'h24, 2'b01, 0, 0);
      step2("n2 load+fd", 1, 1, 1, 8'h65, 7'h30, 2'b10, 1, 1);
      step2("n2 digit1b", 1, 1, 0, 8'h00, 7'h19, 2'b01, 0, 0);
      step2("n2 late xfer", 1, 1, 0, 8'h00, 7'h12, 2'b10, 1, 1);
      step2("n2 digit1c", 1, 1, 0, 8'h00, 7'h02, 2'b01, 0, 0);
      step2("n2 no pend", 1, 1, 0, 8'h00, 7'h12, 2'b10, 1, 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
